wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port of the Writeback stage among NUM_REQ
//  completing execution units (ALU, MUL, LSU). Round-robin arbitration, valid/ready
//  handshake per requester, one registered write per cycle. Also owns the retire
//  stream (address of each written-back insn) and the retired-instruction counter.
// PARAMETERS
//  NUM_REQ     3   number of requesters (2..8)
//  XLEN        32  register data width
//  REG_ADDR_W  5   register index width
//  ADDR_WIDTH  32  byte address width; insn addresses carried word-aligned (ADDR_WIDTH-2 bits)
// PORTS
//  clk           in   1                      clock
//  rst           in   1                      reset, asynchronous, active-low
//  req_valid     in   NUM_REQ                requester i has a result
//  req_ready     out  NUM_REQ                requester i granted this cycle (one-hot or 0)
//  req_rd        in   NUM_REQ x REG_ADDR_W   destination register
//  req_data      in   NUM_REQ x XLEN         result value
//  req_addr      in   NUM_REQ x ADDR_WIDTH-2 insn word address
//  wb_stall      in   1                      port borrowed (debug); no grants
//  flush         in   1                      pipeline flush; drop pending write
//  rf_we         out  1                      register-file write enable
//  rf_waddr      out  REG_ADDR_W             write index
//  rf_wdata      out  XLEN                   write data
//  retire_valid  out  1                      one insn retired this cycle
//  retire_addr   out  ADDR_WIDTH             byte address {word_addr,2'b00}
//  retire_cnt    out  64                     retired-insn count
// BEHAVIOUR
//  - Reset (rst low, async): rf_we=0, retire_valid=0, rf_waddr/rf_wdata/retire_addr=0,
//    retire_cnt=0, RR pointer=0; req_ready=0 while in reset.
//  - Grant (combinational): if wb_stall|flush, no grant. Else first i with req_valid[i]
//    scanning from pointer upward, modulo NUM_REQ. req_ready = one-hot grant.
//    Transfer when req_valid[i]&req_ready[i]; requester must hold payload until then.
//  - Pointer: after a transfer by i, pointer = (i+1) mod NUM_REQ; else unchanged.
//  - Latency: transfer in cycle N -> rf_we/retire_valid in cycle N+1 (output register).
//    No transfer in N -> rf_we=0, retire_valid=0 in N+1; data outputs hold last value.
//  - rd==0: retire_valid=1, rf_we=0 (x0 never written).
//  - retire_cnt += 1 in the cycle retire_valid rises for an insn; wraps 2^64-1 -> 0.
//  - flush in cycle N: no grant in N; output register cleared in N+1 (a transfer in
//    N-1 still writes in N, unaffected). Pointer unchanged by flush.
//  - wb_stall: no grants; already-registered write completes normally.
//  - Requester dropping req_valid without transfer: legal, no side effect.
// CONFIGURATION
//  WB_PERF_EN defined: adds output perf_stall_cnt (NUM_REQ x 32): counter i increments
//    each cycle req_valid[i]&!req_ready[i]; saturates at 32'hFFFF_FFFF; reset to 0.
//  WB_PERF_EN undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package stage: typedef WbReq {rd, data, addr}; constant NUM_WB_REQ=3.
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot grant, grant index.
//  - Top: pointer register, output register, retire counter, optional perf counters.
// TESTING
//  1 Single req: req_valid=001, rd=5, data=32'hDEAD_BEEF, addr=30'h100 -> ready=001
//    same cycle; next cycle rf_we=1, waddr=5, wdata=DEADBEEF, retire_addr=32'h400, cnt=1.
//  2 All valid held 6 cycles, ptr=0 -> grants 001,010,100,001,010,100; cnt=6.
//  3 rd=0 from req1 -> retire_valid=1, rf_we=0, retire_cnt increments.
//  4 flush with req_valid=111 -> ready=000 that cycle; next cycle rf_we=0, ptr unchanged.
//  5 rst low mid-stream with rf_we=1 -> outputs 0 immediately (no clk), cnt=0, ptr=0.
//  6 WB_PERF_EN: req2 valid under wb_stall 10 cycles -> perf_stall_cnt[2]=10, others 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter.
// Optional feature macro: WB_PERF_EN (per-requester stall counters).
package wb_port_arbiter_pkg;

  localparam int NUM_WB_REQ     = 3;
  localparam int WB_XLEN        = 32;
  localparam int WB_REG_ADDR_W  = 5;
  localparam int WB_WORD_ADDR_W = 30;

  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0]  rd;
    logic [WB_XLEN-1:0]        data;
    logic [WB_WORD_ADDR_W-1:0] addr;
  } WbReq;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side valid/ready handshake bundle for the writeback port.
interface wb_port_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_WIDTH = 32
);

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_rd;
  logic [NUM_REQ-1:0][XLEN-1:0]         req_data;
  logic [NUM_REQ-1:0][ADDR_WIDTH-3:0]   req_addr;

  modport master (
    output req_valid, req_rd, req_data, req_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_data, req_addr,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW:0]   pos;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        grant[pos[IW-1:0]]   = 1'b1;
        idx                  = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback register-file port arbiter with retire stream and retire counter.
// Optional macro WB_PERF_EN adds saturating per-requester stall counters.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_WB_REQ,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_port_arbiter_if.slave      req,
  input  logic                  wb_stall,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  retire_valid,
  output logic [ADDR_WIDTH-1:0] retire_addr,
  output logic [63:0]           retire_cnt
`ifdef WB_PERF_EN
  , output logic [NUM_REQ-1:0][31:0] perf_stall_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] gnt;
  logic               grant_en;
  logic               xfer;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req.req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // rst is folded in so no requester sees ready while the block is held in reset.
  assign grant_en      = rst & ~wb_stall & ~flush;
  assign req.req_ready = grant_en ? gnt : '0;
  assign xfer          = grant_en & (|gnt);
  assign ptr_next      = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      rf_we        <= 1'b0;
      retire_valid <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_addr  <= '0;
      retire_cnt   <= '0;
    end else begin
      rf_we        <= xfer && (req.req_rd[gnt_idx] != '0);
      retire_valid <= xfer;
      if (xfer) begin
        ptr         <= ptr_next;
        rf_waddr    <= req.req_rd[gnt_idx];
        rf_wdata    <= req.req_data[gnt_idx];
        retire_addr <= {req.req_addr[gnt_idx], 2'b00};
        retire_cnt  <= retire_cnt + 64'd1;
      end
    end
  end

`ifdef WB_PERF_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        perf_stall_cnt[g] <= '0;
      end else if (req.req_valid[g] && !req.req_ready[g] && (perf_stall_cnt[g] != '1)) begin
        perf_stall_cnt[g] <= perf_stall_cnt[g] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed + randomized bench for wb_port_arbiter against a behavioural model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N = NUM_WB_REQ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_addr;
  logic [63:0] retire_cnt;
`ifdef WB_PERF_EN
  logic [N-1:0][31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .ADDR_WIDTH(32)) bus ();

  wb_port_arbiter #(.NUM_REQ(N), .XLEN(32), .REG_ADDR_W(5), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus),
    .wb_stall     (wb_stall),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .retire_addr  (retire_addr),
    .retire_cnt   (retire_cnt)
`ifdef WB_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the spec says is pending and what the outputs should show.
  WbReq            pend[N];
  bit              pv[N];
  int              m_ptr;
  bit              m_we, m_rv;
  WbReq            m_out;
  longint unsigned m_cnt;
  logic [N-1:0]    last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic new_payload(input int i, input bit nonzero_rd);
    pend[i].rd   = nonzero_rd ? 5'($urandom_range(1, 31)) : 5'($urandom);
    pend[i].data = $urandom;
    pend[i].addr = 30'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_rd[i]    = pend[i].rd;
      bus.req_data[i]  = pend[i].data;
      bus.req_addr[i]  = pend[i].addr;
    end
  endtask

  task automatic check_outputs();
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("retire_valid", 64'(retire_valid), 64'(m_rv));
    check("rf_waddr", 64'(rf_waddr), 64'(m_out.rd));
    check("rf_wdata", 64'(rf_wdata), 64'(m_out.data));
    check("retire_addr", 64'(retire_addr), 64'(m_out.addr) * 4);
    check("retire_cnt", retire_cnt, m_cnt);
  endtask

  // One clock: inputs driven at negedge, ready checked mid-low, outputs after posedge.
  task automatic cycle();
    int g;
    drive();
    #1;
    g = (wb_stall || flush) ? -1 : model_pick();
    last_ready = bus.req_ready;
    check("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk);
    if (g >= 0) begin
      m_rv  = 1'b1;
      m_we  = (pend[g].rd != 0);
      m_out = pend[g];
      m_cnt = m_cnt + 1;
      m_ptr = (g + 1) % N;
      pv[g] = 1'b0;
    end else begin
      m_rv = 1'b0;
      m_we = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 1'b0;
    m_rv  = 1'b0;
    m_out = '0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pend[i] = '0; end
    pv[0] = 1'b1;
    drive();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check_outputs();
    @(negedge clk);
    pv[0] = 1'b0;
    drive();
    rst = 1'b1;
  endtask

  initial begin
    int p0;
    do_reset();

    // Single request from requester 0.
    pv[0] = 1'b1;
    pend[0] = '{rd: 5'd5, data: 32'hDEAD_BEEF, addr: 30'h100};
    cycle();
    check("t1_ready", 64'(last_ready), 64'b001);
    check("t1_we", 64'(rf_we), 64'd1);
    check("t1_addr", 64'(retire_addr), 64'h400);
    check("t1_cnt", retire_cnt, 64'd1);

    // All valid for six cycles from pointer 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; new_payload(i, 1'b1); end
      cycle();
      check("t2_grant", 64'(last_ready), 64'd1 << (k % 3));
    end
    check("t2_cnt", retire_cnt, 64'd6);

    // rd==0 retires without writing.
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    pv[1] = 1'b1;
    new_payload(1, 1'b1);
    pend[1].rd = 5'd0;
    cycle();
    check("t3_we", 64'(rf_we), 64'd0);
    check("t3_rv", 64'(retire_valid), 64'd1);
    check("t3_cnt", retire_cnt, 64'd7);

    // Flush blocks grants and leaves the pointer alone.
    for (int i = 0; i < N; i++) begin pv[i] = 1'b1; new_payload(i, 1'b1); end
    p0 = m_ptr;
    flush = 1'b1;
    cycle();
    check("t4_ready", 64'(last_ready), 64'd0);
    check("t4_we", 64'(rf_we), 64'd0);
    flush = 1'b0;
    cycle();
    check("t4_ptr", 64'(last_ready), 64'd1 << p0);

    // Asynchronous reset while a write is being presented.
    for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; new_payload(i, 1'b1); end
    cycle();
    check("t5_we_pre", 64'(rf_we), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("t5_ready", 64'(bus.req_ready), 64'd0);
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b1; new_payload(i, 1'b1); end
    cycle();
    check("t5_ptr0", 64'(last_ready), 64'b001);

`ifdef WB_PERF_EN
    do_reset();
    pv[2] = 1'b1;
    new_payload(2, 1'b1);
    wb_stall = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    wb_stall = 1'b0;
    check("t6_perf2", 64'(perf_stall_cnt[2]), 64'd10);
    check("t6_perf1", 64'(perf_stall_cnt[1]), 64'd0);
    check("t6_perf0", 64'(perf_stall_cnt[0]), 64'd0);
`endif

    // Randomized traffic; pending payloads are held until transferred.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          pv[i] = ($urandom_range(0, 2) != 0);
          new_payload(i, 1'b0);
        end else if ($urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      wb_stall = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      cycle();
    end
    wb_stall = 1'b0;
    flush    = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
